// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_seq
// Purpose  : 16x16->32 shift-and-add multiply sequencer that time-shares an
//            external combinational ALU (sign-magnitude pre/post in signed mode)
// Revision : 1.0  initial release
// ============================================================================
module alu_mul_seq #(
    parameter logic [2:0] OP_ADD = 3'b100,
    parameter int         WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     alu_A,
    output logic [WIDTH-1:0]     alu_B,
    output logic                 alu_Cin,
    output logic [2:0]           alu_Op,
    output logic                 alu_invA,
    output logic                 alu_invB,
    output logic                 alu_sign,
    input  logic [WIDTH-1:0]     alu_Out,
    input  logic                 alu_OFL,
    input  logic                 alu_Zero
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ABS_A  = 3'd1,
        S_ABS_B  = 3'd2,
        S_MUL    = 3'd3,
        S_NEG_LO = 3'd4,
        S_NEG_HI = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     m_q, hi_q, lo_q;
    logic [WIDTH-1:0]     m_d, hi_d, lo_d;
    logic [3:0]           cnt_q;
    logic                 neg_q;
    logic                 c_q;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   product_q;
    logic                 enter_done;
    logic                 unused_zero;

    assign unused_zero = alu_Zero;

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

    // ALU operands are decoded from registered state so Out/OFL settle within the cycle.
    always_comb begin
        alu_Op   = OP_ADD;
        alu_sign = 1'b0;
        alu_invB = 1'b0;
        alu_A    = '0;
        alu_B    = '0;
        alu_Cin  = 1'b0;
        alu_invA = 1'b0;
        case (state_q)
            S_ABS_A: begin
                alu_A    = m_q;
                alu_invA = m_q[WIDTH-1];
                alu_Cin  = m_q[WIDTH-1];
            end
            S_ABS_B: begin
                alu_A    = lo_q;
                alu_invA = lo_q[WIDTH-1];
                alu_Cin  = lo_q[WIDTH-1];
            end
            S_MUL: begin
                alu_A = hi_q;
                alu_B = lo_q[0] ? m_q : '0;
            end
            S_NEG_LO: begin
                alu_A    = lo_q;
                alu_invA = 1'b1;
                alu_Cin  = 1'b1;
            end
            S_NEG_HI: begin
                alu_A    = hi_q;
                alu_invA = 1'b1;
                alu_Cin  = c_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        m_d  = m_q;
        hi_d = hi_q;
        lo_d = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d  = a;
                    hi_d = '0;
                    lo_d = b;
                end
            end
            S_ABS_A:  m_d  = alu_Out;
            S_ABS_B:  lo_d = alu_Out;
            // 33-bit {carry, sum, LO} shifted right by one, low bit discarded
            S_MUL:    {hi_d, lo_d} = {alu_OFL, alu_Out, lo_q[WIDTH-1:1]};
            S_NEG_LO: lo_d = alu_Out;
            S_NEG_HI: hi_d = alu_Out;
            default: ;
        endcase
    end

    assign enter_done = ((state_q == S_MUL) && (cnt_q == 4'd15) && !neg_q)
                     || (state_q == S_NEG_HI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= 4'd0;
            neg_q     <= 1'b0;
            c_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            m_q    <= m_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= 1'b0;
            if (enter_done) begin
                busy_q    <= 1'b0;
                done_q    <= 1'b1;
                product_q <= {hi_d, lo_d};
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        neg_q   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= signed_mode ? S_ABS_A : S_MUL;
                    end
                end
                S_ABS_A: state_q <= S_ABS_B;
                S_ABS_B: state_q <= S_MUL;
                S_MUL: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15)
                        state_q <= neg_q ? S_NEG_LO : S_DONE;
                end
                S_NEG_LO: begin
                    c_q     <= alu_OFL;
                    state_q <= S_NEG_HI;
                end
                S_NEG_HI: state_q <= S_DONE;
                S_DONE:   state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mul_seq
// Purpose  : directed + random checks of alu_mul_seq against an arithmetic model
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_mode;
    logic [15:0] a, b;
    logic        busy, done;
    logic [31:0] product;
    logic [15:0] alu_A, alu_B, alu_Out;
    logic        alu_Cin, alu_invA, alu_invB, alu_sign, alu_OFL, alu_Zero;
    logic [2:0]  alu_Op;
    logic [16:0] alu_sum;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_prod;

    always #5 clk = ~clk;

    alu_mul_seq dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy), .done(done), .product(product),
        .alu_A(alu_A), .alu_B(alu_B), .alu_Cin(alu_Cin), .alu_Op(alu_Op),
        .alu_invA(alu_invA), .alu_invB(alu_invB), .alu_sign(alu_sign),
        .alu_Out(alu_Out), .alu_OFL(alu_OFL), .alu_Zero(alu_Zero)
    );

    // Combinational ALU: A+B+Cin with optional inversion, carry-out as OFL
    assign alu_sum  = {1'b0, (alu_invA ? ~alu_A : alu_A)}
                    + {1'b0, (alu_invB ? ~alu_B : alu_B)} + 17'(alu_Cin);
    assign alu_Out  = alu_sum[15:0];
    assign alu_OFL  = alu_sum[16];
    assign alu_Zero = (alu_Out == 16'd0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_prod(input logic [15:0] x, input logic [15:0] y,
                                             input logic sm);
        longint p;
        if (sm) p = longint'($signed(x)) * longint'($signed(y));
        else    p = longint'(x) * longint'(y);
        return p[31:0];
    endfunction

    // Caller must be #1 after a rising edge with the DUT idle; this is cycle 0.
    // Returns in the done cycle, or (inject) one cycle later with the DUT idle.
    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic sm,
                          input bit inject);
        int          lat, seen;
        logic [31:0] exp;
        bit          busy_ok, hold_ok, neg;
        logic        inva19, cin19;
        exp     = ref_prod(x, y, sm);
        neg     = sm && (x[15] ^ y[15]);
        lat     = !sm ? 17 : (neg ? 21 : 19);
        a = x; b = y; signed_mode = sm; start = 1'b1;
        seen = 0; busy_ok = 1; hold_ok = 1; inva19 = 1'bx; cin19 = 1'bx;
        for (int c = 1; c <= 40 && seen == 0; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            a = 16'($urandom); b = 16'($urandom); signed_mode = 1'($urandom);
            if (inject && c == 5) start = 1'b1;
            if (c == 19) begin inva19 = alu_invA; cin19 = alu_Cin; end
            if (done) seen = c;
            else begin
                if (busy !== 1'b1) busy_ok = 0;
                if (product !== last_prod) hold_ok = 0;
            end
        end
        chk("latency", 32'(seen), 32'(lat));
        chk("product", product, exp);
        chk("busy_while_active", 32'(busy_ok), 32'd1);
        chk("product_hold", 32'(hold_ok), 32'd1);
        if (neg) begin
            chk("neglo_invA", 32'(inva19), 32'd1);
            chk("neglo_cin", 32'(cin19), 32'd1);
        end
        last_prod = exp;
        if (inject) begin
            start = 1'b1; a = 16'h1234; b = 16'h4321; signed_mode = 1'b0;
            @(posedge clk); #1;
            start = 1'b0;
            chk("ignored_start_busy", 32'(busy), 32'd0);
            chk("done_one_cycle", 32'(done), 32'd0);
            chk("product_after_ignored", product, exp);
        end
    endtask

    task automatic chk_quiet(input string pfx);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
        chk({pfx, "_done"}, 32'(done), 32'd0);
        chk({pfx, "_product"}, product, 32'd0);
        chk({pfx, "_aluA"}, 32'(alu_A), 32'd0);
        chk({pfx, "_aluB"}, 32'(alu_B), 32'd0);
        chk({pfx, "_aluCin"}, 32'(alu_Cin), 32'd0);
        chk({pfx, "_aluInvA"}, 32'(alu_invA), 32'd0);
        chk({pfx, "_aluInvB"}, 32'(alu_invB), 32'd0);
        chk({pfx, "_aluSign"}, 32'(alu_sign), 32'd0);
        chk({pfx, "_aluOp"}, 32'(alu_Op), 32'd4);
    endtask

    initial begin
        logic [15:0] rx, ry;
        logic        rs;
        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
        last_prod = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset");
        rst = 1'b0;

        @(posedge clk); #1;
        run_op(16'h0003, 16'h0005, 1'b0, 1'b0);
        @(posedge clk); #1;
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        run_op(16'hFFFD, 16'h0005, 1'b1, 1'b0);
        @(posedge clk); #1;
        run_op(16'h8000, 16'h8000, 1'b1, 1'b0);
        @(posedge clk); #1;
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0);

        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            rx = 16'($urandom);
            ry = 16'($urandom);
            rs = 1'($urandom);
            if (i == 0) rx = 16'h0000;
            if (i == 1) ry = 16'h7FFF;
            run_op(rx, ry, rs, 1'b0);
        end

        @(posedge clk); #1;
        a = 16'h1234; b = 16'h5678; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_quiet("midop_reset");
        @(posedge clk); #2;
        rst = 1'b0;
        last_prod = '0;
        @(posedge clk); #1;
        chk("post_reset_idle", 32'(busy), 32'd0);
        run_op(16'd7, 16'd6, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
